// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared widths and colour type for the RGB status LED driver
package led_matrix_pkg;
    localparam int PWM_BITS = 8;
    localparam int HUE_BITS = 10;
    localparam int HUE_MAX  = 768;
    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } rgb_t;
endpackage

// File: rtl/led_matrix_if.sv
// led_matrix_if: hue request and colour answer between the sequencer and the mapper
interface led_matrix_if;
    import led_matrix_pkg::*;
    logic [HUE_BITS-1:0] hue;
    rgb_t                rgb;
    modport master (output hue, input rgb);
    modport slave  (input hue, output rgb);
endinterface

// File: rtl/led_matrix_hue_to_rgb.sv
// hue_to_rgb: combinational colour wheel, three 256-wide linear segments
module hue_to_rgb
    import led_matrix_pkg::*;
(
    led_matrix_if.slave hif
);
    logic [1:0]          seg;
    logic [PWM_BITS-1:0] f;
    logic [PWM_BITS-1:0] fr;
    assign seg = hif.hue[HUE_BITS-1:PWM_BITS];
    assign f   = hif.hue[PWM_BITS-1:0];
    assign fr  = ~f;
    // seg 3 cannot occur because hue stays below 768
    assign hif.rgb = (seg == 2'd0) ? rgb_t'{fr, f, '0} :
                     (seg == 2'd1) ? rgb_t'{'0, fr, f} :
                     (seg == 2'd2) ? rgb_t'{f, '0, fr} : rgb_t'('0);
endmodule

// File: rtl/led_matrix_top.sv
// led_matrix_top: sweeps the active-low RGB status LED around the colour wheel with 8-bit PWM
module led_matrix_top
    import led_matrix_pkg::*;
#(
    parameter int PRESCALE        = 4,
    parameter int HUE_STEP        = 8,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic OSC_CLK_IN,
    input  logic RESET_,
    output logic LED_R_,
    output logic LED_G_,
    output logic LED_B_
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic [PW-1:0]       pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FW-1:0]       frame_cnt;
    logic [HUE_BITS-1:0] hue;
    logic [HUE_BITS-1:0] hue_next;
    logic [HUE_BITS:0]   hue_sum;
    rgb_t                duty;
    logic                tick;
    logic                period_end;
    logic                step;

    led_matrix_if hif ();
    assign hif.hue = hue;
    hue_to_rgb u_map (.hif(hif));

    assign tick       = pre_cnt == PW'(PRESCALE - 1);
    assign period_end = tick && (pwm_cnt == '1);
    assign step       = period_end && (frame_cnt == FW'(FRAMES_PER_STEP - 1));
    assign hue_sum    = {1'b0, hue} + (HUE_BITS+1)'(HUE_STEP);
    assign hue_next   = (hue_sum >= (HUE_BITS+1)'(HUE_MAX)) ?
                        HUE_BITS'(hue_sum - (HUE_BITS+1)'(HUE_MAX)) : hue_sum[HUE_BITS-1:0];

    // duty latches the colour of the pre-update hue, so a new hue shows one period later
    always_ff @(posedge OSC_CLK_IN or negedge RESET_) begin
        if (!RESET_) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            frame_cnt <= '0;
            hue       <= '0;
            duty      <= rgb_t'{8'hff, 8'h00, 8'h00};
            LED_R_    <= 1'b1;
            LED_G_    <= 1'b1;
            LED_B_    <= 1'b1;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end) begin
                frame_cnt <= step ? '0 : frame_cnt + 1'b1;
                duty      <= hif.rgb;
            end
            if (step) hue <= hue_next;
            LED_R_ <= ~(pwm_cnt < duty.r);
            LED_G_ <= ~(pwm_cnt < duty.g);
            LED_B_ <= ~(pwm_cnt < duty.b);
        end
    end
endmodule

// File: tb/tb_led_matrix_top.sv
// tb_led_matrix_top: scoreboard bench checking PWM patterns per period, hue sequencing and the mapper
module tb_led_matrix_top;
    import led_matrix_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    logic led_r, led_g, led_b;
    logic led2_r, led2_g, led2_b;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_r_rise = 0;
    logic [2:0] first_leds;

    typedef struct {int r; int g; int b;} exp_t;
    exp_t sb_q[$];
    exp_t map_q[$];
    int   hue_q[$];

    always #40 clk = ~clk;

    led_matrix_top dut (
        .OSC_CLK_IN(clk), .RESET_(rst_n), .LED_R_(led_r), .LED_G_(led_g), .LED_B_(led_b)
    );

    led_matrix_top #(.PRESCALE(1), .HUE_STEP(255), .FRAMES_PER_STEP(1)) dut2 (
        .OSC_CLK_IN(clk), .RESET_(rst2_n), .LED_R_(led2_r), .LED_G_(led2_g), .LED_B_(led2_b)
    );

    led_matrix_if mif ();
    hue_to_rgb u_map (.hif(mif));

    function automatic exp_t wheel(input int h);
        exp_t e;
        int f;
        f = h % 256;
        case (h / 256)
            0:       e = '{255 - f, f, 0};
            1:       e = '{0, 255 - f, f};
            default: e = '{f, 0, 255 - f};
        endcase
        return e;
    endfunction

    // period p (1-based after release) shows the colour of hue after p-2 updates of 8
    function automatic exp_t period_duty(input int p);
        if (p <= 2) return wheel(0);
        return wheel(((p - 2) * 8) % 768);
    endfunction

    task automatic push_periods(input int a, input int b);
        for (int p = a; p <= b; p++) sb_q.push_back(period_duty(p));
    endtask

    task automatic scoreboard_period(input int p);
        exp_t e;
        int lit_r = 0, lit_g = 0, lit_b = 0;
        int mis_r = 0, mis_g = 0, mis_b = 0;
        logic prev_r;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: period %0d has no expected entry", p);
            return;
        end
        e = sb_q.pop_front();
        prev_r = led_r;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (i == 0) first_leds = {led_r, led_g, led_b};
            if (prev_r === 1'b0 && led_r === 1'b1) last_r_rise = cyc;
            prev_r = led_r;
            lit_r += int'(led_r === 1'b0);
            lit_g += int'(led_g === 1'b0);
            lit_b += int'(led_b === 1'b0);
            mis_r += int'((led_r === 1'b0) !== (i / 4 < e.r));
            mis_g += int'((led_g === 1'b0) !== (i / 4 < e.g));
            mis_b += int'((led_b === 1'b0) !== (i / 4 < e.b));
        end
        if (mis_r !== 0) begin
            errors++;
            $display("FAIL period%0d_red: lit %0d clocks (%0d misplaced), expected %0d", p, lit_r, mis_r, 4 * e.r);
        end
        checks++;
        if (mis_g !== 0) begin
            errors++;
            $display("FAIL period%0d_green: lit %0d clocks (%0d misplaced), expected %0d", p, lit_g, mis_g, 4 * e.g);
        end
        checks++;
        if (mis_b !== 0) begin
            errors++;
            $display("FAIL period%0d_blue: lit %0d clocks (%0d misplaced), expected %0d", p, lit_b, mis_b, 4 * e.b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            errors++;
            $display("FAIL reset_early: leds %b, expected 111", {led_r, led_g, led_b});
        end
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            errors++;
            $display("FAIL reset_hold: leds %b, expected 111", {led_r, led_g, led_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_period();
        int r1;
        push_periods(1, 2);
        scoreboard_period(1);
        checks++;
        if (first_leds !== 3'b011) begin
            errors++;
            $display("FAIL first_edge: leds %b, expected 011", first_leds);
        end
        r1 = last_r_rise;
        scoreboard_period(2);
        checks++;
        if (last_r_rise - r1 !== 1024) begin
            errors++;
            $display("FAIL period_length: %0d clocks, expected 1024", last_r_rise - r1);
        end
    endtask

    task automatic test_hue_progression();
        push_periods(3, 33);
        for (int p = 3; p <= 33; p++) scoreboard_period(p);
    endtask

    task automatic test_segment_crossing();
        push_periods(34, 34);
        scoreboard_period(34);
    endtask

    task automatic test_mid_reset();
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            errors++;
            $display("FAIL async_reset_a: leds %b, expected 111", {led_r, led_g, led_b});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_periods(1, 4);
        for (int p = 1; p <= 4; p++) scoreboard_period(p);
        // period 5 shows hue 24: R231 G24 B0; stop once pwm_cnt has reached 100
        repeat (401) @(posedge clk);
        #1;
        checks++;
        if ({led_r, led_g, led_b} !== 3'b011) begin
            errors++;
            $display("FAIL pre_reset_p5: leds %b, expected 011", {led_r, led_g, led_b});
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            errors++;
            $display("FAIL async_reset_b: leds %b, expected 111", {led_r, led_g, led_b});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_first_period();
    endtask

    task automatic test_wrap();
        int h = 0;
        int exp_h;
        exp_t e;
        int hues[6] = '{0, 248, 256, 765, 767, 512};
        for (int n = 0; n < 4; n++) begin
            h = (h + 255) % 768;
            hue_q.push_back(h);
        end
        @(negedge clk);
        rst2_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            repeat (256) @(posedge clk);
            #1;
            exp_h = hue_q.pop_front();
            checks++;
            if (dut2.hue !== 10'(exp_h)) begin
                errors++;
                $display("FAIL wrap_hue%0d: hue %0d, expected %0d", n, dut2.hue, exp_h);
            end
        end
        e = wheel(765);
        checks++;
        if ({dut2.duty.r, dut2.duty.g, dut2.duty.b} !== {8'(e.r), 8'(e.g), 8'(e.b)}) begin
            errors++;
            $display("FAIL wrap_duty765: rgb %0d/%0d/%0d, expected %0d/%0d/%0d",
                     dut2.duty.r, dut2.duty.g, dut2.duty.b, e.r, e.g, e.b);
        end
        foreach (hues[i]) map_q.push_back(wheel(hues[i]));
        foreach (hues[i]) begin
            mif.hue = 10'(hues[i]);
            #1;
            e = map_q.pop_front();
            checks++;
            if ({mif.rgb.r, mif.rgb.g, mif.rgb.b} !== {8'(e.r), 8'(e.g), 8'(e.b)}) begin
                errors++;
                $display("FAIL mapper_hue%0d: rgb %0d/%0d/%0d, expected %0d/%0d/%0d",
                         hues[i], mif.rgb.r, mif.rgb.g, mif.rgb.b, e.r, e.g, e.b);
            end
        end
    endtask

    initial begin
        mif.hue = '0;
        test_reset();
        test_first_period();
        test_hue_progression();
        test_segment_crossing();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
